// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with a busy scoreboard for
// multi-cycle results (loads, MULT/DIV).
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   rd_addr / rd_data   READ_PORTS combinational read ports, port k packed at
//                       [k*AW +: AW] / [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy             per read port: addressed register awaits a completion
//   wr0_*               single-cycle (ALU) writeback port
//   wr1_*               late-completion writeback port, clears the busy bit
//   rsv_en, rsv_addr    reserve a destination register (sets its busy bit)
//   rsv_ok              reservation accepted this cycle (combinational)
//   err                 one-cycle registered pulse on a protocol violation
//   debug_data          registered contents of register DEBUG_REG
//
// Register 0 is hard-wired to zero, is never busy, and always accepts a
// reservation without effect.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int READ_PORTS = 2,
    parameter int DEBUG_REG  = 2,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*AW-1:0]         rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic                             wr0_en,
    input  logic [AW-1:0]                    wr0_addr,
    input  logic [DATA_WIDTH-1:0]            wr0_data,
    input  logic                             wr1_en,
    input  logic [AW-1:0]                    wr1_addr,
    input  logic [DATA_WIDTH-1:0]            wr1_data,
    input  logic                             rsv_en,
    input  logic [AW-1:0]                    rsv_addr,
    output logic                             rsv_ok,
    output logic                             err,
    output logic [DATA_WIDTH-1:0]            debug_data
);

    localparam logic [AW-1:0] DBG_IDX = DEBUG_REG[AW-1:0];

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  err_q, err_d;

    // Writes addressed to register 0 are discarded everywhere.
    logic wr0_hit, wr1_hit;
    assign wr0_hit = wr0_en && (wr0_addr != '0);
    assign wr1_hit = wr1_en && (wr1_addr != '0);

    // Depends only on rsv_*, wr1_* and busy: no path from rd_addr.
    // A completion arriving in the same cycle frees the register for reuse.
    assign rsv_ok = rsv_en && ((rsv_addr == '0) || !busy_q[rsv_addr] ||
                               (wr1_en && (wr1_addr == rsv_addr)));

    // NOTE: every signal assigned in an always_comb gets its default first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        busy_d = busy_q;
        if (wr1_hit)
            busy_d[wr1_addr] = 1'b0;
        // Set after clear: a same-cycle reservation wins over the completion.
        if (rsv_ok && (rsv_addr != '0))
            busy_d[rsv_addr] = 1'b1;

        // Completion without a reservation, or ALU write over a pending
        // result (WAW) unless port 1 overwrites the same register this cycle.
        err_d = (wr1_hit && !busy_q[wr1_addr]) ||
                (wr0_hit && busy_q[wr0_addr] &&
                 !(wr1_hit && (wr1_addr == wr0_addr)));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order; the port-1 write placed
    // after the port-0 write is what gives port 1 priority on a collision.
    // NOTE: the data array is reset deliberately: the register file must read
    // as all-zero after reset, so this memory cannot map onto a reset-less RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wr0_hit)
                regs_q[wr0_addr] <= wr0_data;
            if (wr1_hit)
                regs_q[wr1_addr] <= wr1_data;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign err        = err_q;
    assign debug_data = regs_q[DBG_IDX];

    // Read ports with same-cycle bypass: port 1 data, then port 0, then array.
    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = regs_q[addr];
            if (addr == '0)
                data = '0;
            else if (wr1_en && (wr1_addr == addr))
                data = wr1_data;
            else if (wr0_en && (wr0_addr == addr))
                data = wr0_data;
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
        // busy_q[0] is never set, so register 0 always reports not busy.
        assign rd_busy[k] = busy_q[addr] && !(wr1_en && (wr1_addr == addr));
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the
// register file and scoreboard.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int DBG = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP*DW-1:0]  rd_data;
    logic [RP-1:0]     rd_busy;
    logic              wr0_en, wr1_en, rsv_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, rsv_addr;
    logic [DW-1:0]     wr0_data, wr1_data;
    logic              rsv_ok, err;
    logic [DW-1:0]     debug_data;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];
    bit            m_err;

    reg_file_sb #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .READ_PORTS(RP), .DEBUG_REG(DBG)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .err(err), .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] port_data(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] port_addr(input int k);
        return rd_addr[k*AW +: AW];
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(wr1_en && wr1_addr == a);
    endfunction

    function automatic bit exp_rsv_ok();
        if (!rsv_en) return 1'b0;
        return (rsv_addr == 0) || !m_busy[rsv_addr] || (wr1_en && wr1_addr == rsv_addr);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Applies the inputs present at the clock edge to the model.
    task automatic model_update();
        bit ok, viol;
        if (reset) begin
            model_clear();
            return;
        end
        ok   = exp_rsv_ok();
        viol = 1'b0;
        if (wr1_en && wr1_addr != 0 && !m_busy[wr1_addr]) viol = 1'b1;
        if (wr0_en && wr0_addr != 0 && m_busy[wr0_addr] &&
            !(wr1_en && wr1_addr == wr0_addr)) viol = 1'b1;
        if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
        if (wr1_en && wr1_addr != 0) m_busy[wr1_addr] = 1'b0;
        if (ok && rsv_addr != 0)     m_busy[rsv_addr] = 1'b1;
        m_err = viol;
    endtask

    task automatic chk_model();
        for (int k = 0; k < RP; k++) begin
            check($sformatf("rd_data%0d", k), port_data(k), exp_read(port_addr(k)));
            check($sformatf("rd_busy%0d", k), DW'(rd_busy[k]), DW'(exp_busy(port_addr(k))));
        end
        check("rsv_ok", DW'(rsv_ok), DW'(exp_rsv_ok()));
        check("err", DW'(err), DW'(m_err));
        check("debug_data", debug_data, m_mem[DBG]);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    // Called 1 time unit after a rising edge: settle, compare, take the edge.
    task automatic settle();
        #2;
        chk_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd(0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // Reset state: every address on both ports.
        for (int a = 0; a < NR; a++) begin
            rd(a, NR - 1 - a);
            #1;
            check("rst_rd0", port_data(0), '0);
            check("rst_rd1", port_data(1), '0);
            check("rst_busy", DW'(rd_busy), '0);
        end
        check("rst_err", DW'(err), '0);
        check("rst_debug", debug_data, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Write with same-cycle bypass, then register 0 immunity.
        idle(); rd(5, 0);
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
        settle();
        check("byp_wr0", port_data(0), 32'hDEADBEEF);
        tick();
        idle(); rd(5, 0);
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'h1234;
        settle();
        check("arr_reg5", port_data(0), 32'hDEADBEEF);
        check("reg0_byp", port_data(1), '0);
        tick();
        idle(); rd(5, 0);
        settle();
        check("reg0_after", port_data(1), '0);
        tick();

        // Reservation lifecycle on register 8.
        idle(); rd(8, 8);
        rsv_en = 1; rsv_addr = 8;
        settle();
        check("rsv8_ok", DW'(rsv_ok), 1);
        tick();
        settle();
        check("rsv8_busy", DW'(rd_busy[0]), 1);
        check("rsv8_again", DW'(rsv_ok), 0);
        tick();
        idle(); rd(8, 8);
        wr1_en = 1; wr1_addr = 8; wr1_data = 32'hCAFE;
        settle();
        check("wr1_byp", port_data(1), 32'hCAFE);
        check("wr1_busy_byp", DW'(rd_busy[1]), 0);
        tick();
        idle(); rd(8, 8);
        settle();
        check("wr1_busy_clr", DW'(rd_busy[0]), 0);
        check("wr1_no_err", DW'(err), 0);
        check("wr1_stored", port_data(0), 32'hCAFE);
        tick();

        // Same-cycle collision on register 3, then reserve + complete together.
        idle(); rd(3, 3);
        rsv_en = 1; rsv_addr = 3;
        settle(); tick();
        idle(); rd(3, 3);
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22;
        settle();
        check("coll_byp", port_data(0), 32'h22);
        tick();
        idle(); rd(3, 3);
        rsv_en = 1; rsv_addr = 3;
        settle();
        check("coll_arr", port_data(0), 32'h22);
        check("coll_no_err", DW'(err), 0);
        tick();
        idle(); rd(3, 3);
        rsv_en = 1; rsv_addr = 3;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h33;
        settle();
        check("rsv_wr1_ok", DW'(rsv_ok), 1);
        tick();
        idle(); rd(3, 3);
        settle();
        check("rsv_wins", DW'(rd_busy[0]), 1);
        check("rsv_wins_err", DW'(err), 0);
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h44;
        tick();

        // Violations: unreserved completion, then WAW on reserved register 10.
        idle(); rd(9, 10);
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h99;
        settle(); tick();
        idle(); rd(9, 10);
        rsv_en = 1; rsv_addr = 10;
        settle();
        check("v1_err", DW'(err), 1);
        check("v1_data", port_data(0), 32'h99);
        tick();
        idle(); rd(9, 10);
        wr0_en = 1; wr0_addr = 10; wr0_data = 32'hAA;
        settle();
        check("v1_err_once", DW'(err), 0);
        tick();
        idle(); rd(9, 10);
        settle();
        check("waw_err", DW'(err), 1);
        check("waw_busy", DW'(rd_busy[1]), 1);
        check("waw_data", port_data(1), 32'hAA);
        tick();
        idle(); rd(9, 10);
        wr1_en = 1; wr1_addr = 10; wr1_data = 32'hBB;
        settle();
        check("waw_err_once", DW'(err), 0);
        tick();

        // Debug register, then reset discarding a reservation on register 4.
        idle(); rd(2, 4);
        wr0_en = 1; wr0_addr = 2; wr0_data = 32'h2A;
        settle();
        check("dbg_before", debug_data, '0);
        tick();
        idle(); rd(2, 4);
        rsv_en = 1; rsv_addr = 4;
        settle();
        check("dbg_after", debug_data, 32'h2A);
        tick();
        idle(); rd(2, 4);
        reset = 1'b1;
        settle();
        check("pre_rst_busy", DW'(rd_busy[1]), 1);
        tick();
        reset = 1'b0;
        idle(); rd(2, 4);
        wr1_en = 1; wr1_addr = 4; wr1_data = 32'h44;
        settle();
        check("post_rst_busy", DW'(rd_busy[1]), 0);
        check("post_rst_dbg", debug_data, '0);
        tick();
        idle(); rd(2, 4);
        settle();
        check("post_rst_err", DW'(err), 1);
        tick();

        // Randomized phase: narrow address range to force collisions.
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            rd($urandom_range(0, 7), $urandom_range(0, 7));
            wr0_en   = $urandom_range(0, 1);
            wr0_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_en   = $urandom_range(0, 1);
            wr1_addr = AW'($urandom_range(0, 7));
            wr1_data = $urandom;
            rsv_en   = $urandom_range(0, 1);
            rsv_addr = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) wr0_addr = AW'(DBG);
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised MIPS general-purpose register file with an integrated busy scoreboard for multi-cycle results such as loads and MULT/DIV writeback. It has a configurable number of combinational read ports and two write ports: port 0 for single-cycle ALU writeback, port 1 for late-completing results. Same-cycle write-to-read bypass is included. It sits between decode (reads, reservations) and writeback in the CPU datapath, and exports one debug register (default $v0) to the testbench.

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, register count, power of 2; AW = log2(NUM_REGS)
- READ_PORTS, 2, number of read ports
- DEBUG_REG, 2, index driven onto debug_data
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  READ_PORTS*AW  read addresses, port k at bits [k*AW +: AW]
- rd_data  out  READ_PORTS*DATA_WIDTH  read data, combinational
- rd_busy  out  READ_PORTS  addressed register has an outstanding reservation, combinational
- wr0_en, wr0_addr, wr0_data  in  1 / AW / DATA_WIDTH  port 0 write
- wr1_en, wr1_addr, wr1_data  in  1 / AW / DATA_WIDTH  port 1 completion write
- rsv_en, rsv_addr  in  1 / AW  reserve destination, which sets its busy bit
- rsv_ok  out  1  reservation accepted this cycle, combinational
- err  out  1  registered one-cycle pulse on protocol violation
- debug_data  out  DATA_WIDTH  registered contents of DEBUG_REG, no bypass

## Operation
- Register 0:
  - Reads as 0 on every port; rd_busy is 0.
  - Writes to it on either port are ignored.
  - Reserving it gives rsv_ok=1 and has no effect.
- Read data per port:
  - If wr1_en and wr1_addr matches (nonzero): wr1_data.
  - Else if wr0_en and wr0_addr matches (nonzero): wr0_data.
  - Else: the array value.
- rd_busy per port = busy[addr] && !(wr1_en && wr1_addr==addr).
- Write priority:
  - When both ports write the same address in one cycle, port 1 data is stored and port 0 data is dropped, with no err.
  - Different addresses are written independently.
- Port 1 completion:
  - Writes data and clears busy[wr1_addr].
  - If busy[wr1_addr] was 0, the write is still performed and err pulses.
- Port 0 writing a busy register:
  - Data is written, busy is unchanged, and err pulses (WAW hazard).
  - The later port-1 completion overwrites it.
- Reservation:
  - rsv_ok = rsv_en && (addr==0 || !busy[addr] || (wr1_en && wr1_addr==addr)).
  - When rsv_ok, busy[addr] is 1 next cycle, including when it is simultaneously cleared by port 1 (set wins).
  - When rsv_en && !rsv_ok, nothing changes. Decode stalls and retries.
- err is registered: high for exactly the cycle after any violation. Multiple violations in one cycle give one pulse.
- Reset clears all registers, all busy bits, err, and debug_data to 0. This takes priority over every write and reservation in the same cycle.

## Timing
- Read latency: 0 cycles (combinational), including bypass of same-cycle writes.
- Write-to-array: value present in the array from the cycle after wr*_en.
- debug_data reflects a write one cycle after the write edge, i.e. the same cycle the array updates.
- Reserve-to-busy: rd_busy asserts the cycle after rsv_ok.
- Reset mid-operation: outstanding reservations are discarded. A port-1 completion arriving after reset writes data and pulses err.
- No combinational path from rd_addr to rsv_ok. rsv_ok depends only on rsv_*, wr1_*, and busy.

## Test plan
- Reset, then read all addresses on all ports -> rd_data=0, rd_busy=0, err=0, debug_data=0.
- wr0 reg 5 = 0xDEADBEEF while reading reg 5 in the same cycle -> rd_data=0xDEADBEEF that cycle and after; write 0x1234 to reg 0 -> reg 0 still reads 0.
- Reservation lifecycle on reg 8:
  - rsv reg 8 -> rsv_ok=1; next cycle rd_busy=1.
  - Second rsv of reg 8 -> rsv_ok=0.
  - wr1 reg 8 = 0xCAFE -> same-cycle rd_data=0xCAFE and rd_busy=0; next cycle busy clear, err=0.
- Same cycle: wr0 reg 3 = 0x11 and wr1 reg 3 = 0x22 (reg 3 reserved) -> read 0x22 both cycles, no err. Same cycle rsv reg 3 + wr1 reg 3 -> busy remains 1.
- Violations:
  - wr1 reg 9 with busy=0 -> data stored, err high for exactly one cycle.
  - wr0 to reserved reg 10 -> err one cycle, busy still 1.
- wr0 reg 2 (DEBUG_REG) = 0x2A -> debug_data=0x2A one cycle later. Assert reset while reg 4 is reserved -> busy cleared next cycle. Later wr1 reg 4 -> err pulses.
